// File: rtl/lc3b_pipe_stage_if.sv
// Valid/ready handshake bus for a single lc3b pipeline payload stream.
interface lc3b_pipe_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             is_nop;

  // Producer side: offers payload, observes ready
  modport master (output valid, output data, output is_nop, input ready);
  // Consumer side: observes payload, returns ready
  modport slave  (input valid, input data, input is_nop, output ready);
endinterface

// File: rtl/lc3b_pipe_stage.sv
// Elastic lc3b pipeline-stage register: one payload bus under valid/ready,
// optional 2-entry skid storage, flush-to-NOP and a saturating stall counter.
module lc3b_pipe_stage #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  lc3b_pipe_stage_if.slave    in_bus,
  lc3b_pipe_stage_if.master   out_bus,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_nop_q, head_nop_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic             tail_nop_q, tail_nop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_c;
  logic             out_valid_c;
  logic             push_c;
  logic             pop_c;

  // Outputs come straight from state; the head register always holds NOP when empty
  assign out_valid_c    = (occ_q != 2'd0);
  assign out_bus.valid  = out_valid_c;
  assign out_bus.data   = head_data_q;
  assign out_bus.is_nop = head_nop_q;
  assign occupancy      = occ_q;
  assign stall_cnt      = cnt_q;

  // Plain stage passes downstream ready through; skid stage depends only on its own fill
  generate
    if (DEPTH == 1) begin : g_plain
      assign ready_c = (occ_q == 2'd0) || out_bus.ready;
    end else begin : g_skid
      assign ready_c = (occ_q < 2'd2);
    end
  endgenerate

  assign in_bus.ready = reset_n && ready_c;
  assign push_c       = in_bus.valid && in_bus.ready;
  assign pop_c        = out_valid_c && out_bus.ready;

  // Next-state: ordered head/tail storage, flush overriding any push or pop
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_nop_d  = head_nop_q;
    tail_data_d = tail_data_q;
    tail_nop_d  = tail_nop_q;
    cnt_d       = cnt_q;

    if (out_valid_c && !out_bus.ready && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      occ_d       = 2'd0;
      head_data_d = NOP_PAYLOAD;
      head_nop_d  = 1'b1;
      tail_data_d = NOP_PAYLOAD;
      tail_nop_d  = 1'b1;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push_c) begin
            occ_d       = 2'd1;
            head_data_d = in_bus.data;
            head_nop_d  = in_bus.is_nop;
          end
        end
        2'd1: begin
          if (push_c && pop_c) begin
            head_data_d = in_bus.data;
            head_nop_d  = in_bus.is_nop;
          end else if (push_c) begin
            occ_d       = 2'd2;
            tail_data_d = in_bus.data;
            tail_nop_d  = in_bus.is_nop;
          end else if (pop_c) begin
            occ_d       = 2'd0;
            head_data_d = NOP_PAYLOAD;
            head_nop_d  = 1'b1;
          end
        end
        default: begin
          if (pop_c) begin
            occ_d       = 2'd1;
            head_data_d = tail_data_q;
            head_nop_d  = tail_nop_q;
            tail_data_d = NOP_PAYLOAD;
            tail_nop_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q       <= 2'd0;
      head_data_q <= NOP_PAYLOAD;
      head_nop_q  <= 1'b1;
      tail_data_q <= NOP_PAYLOAD;
      tail_nop_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_nop_q  <= head_nop_d;
      tail_data_q <= tail_data_d;
      tail_nop_q  <= tail_nop_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
